arm_multicycle_ctrl: RTL and testbench

//  Main control FSM that sequences the shared armreduced datapath (register file, ALU, extend, one memory port)
//  as a multicycle ARM subset processor: LDR/STR, data-processing (ADD/SUB/AND/ORR/CMP, reg or imm), B.

---
 rtl/arm_ctrl_pkg.sv | 69 ++++++
 rtl/arm_cond_check.sv | 41 ++++
 rtl/arm_multicycle_ctrl.sv | 167 ++++++++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared types and encodings for the multicycle ARM-subset controller
package arm_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_UND = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   // Unrecognised commands fall back to ADD so the datapath always sees a defined op.
   function automatic logic [1:0] cmd_to_alu(input logic [3:0] cmd);
      case (cmd)
         CMD_ADD: return ALU_ADD;
         CMD_SUB: return ALU_SUB;
         CMD_CMP: return ALU_SUB;
         CMD_AND: return ALU_AND;
         CMD_ORR: return ALU_ORR;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/arm_cond_check.sv
// rtl/arm_cond_check.sv - ARM condition field evaluation against the NZCV flags
module arm_cond_check
   import arm_ctrl_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_nzcv,
   output logic       o_cond_ex
);

   logic w_n, w_z, w_c, w_v, w_ge;

   assign w_n  = i_nzcv[3];
   assign w_z  = i_nzcv[2];
   assign w_c  = i_nzcv[1];
   assign w_v  = i_nzcv[0];
   assign w_ge = (w_n == w_v);

   // 1111 is the reserved "never" encoding and always fails.
   always_comb begin
      o_cond_ex = 1'b0;
      case (i_cond)
         COND_EQ: o_cond_ex = w_z;
         COND_NE: o_cond_ex = ~w_z;
         COND_CS: o_cond_ex = w_c;
         COND_CC: o_cond_ex = ~w_c;
         COND_MI: o_cond_ex = w_n;
         COND_PL: o_cond_ex = ~w_n;
         COND_VS: o_cond_ex = w_v;
         COND_VC: o_cond_ex = ~w_v;
         COND_HI: o_cond_ex = w_c & ~w_z;
         COND_LS: o_cond_ex = ~w_c | w_z;
         COND_GE: o_cond_ex = w_ge;
         COND_LT: o_cond_ex = ~w_ge;
         COND_GT: o_cond_ex = ~w_z & w_ge;
         COND_LE: o_cond_ex = w_z | ~w_ge;
         COND_AL: o_cond_ex = 1'b1;
         default: o_cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// rtl/arm_multicycle_ctrl.sv - main control FSM for the multicycle ARM-subset datapath
module arm_multicycle_ctrl
   import arm_ctrl_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         cond,
   input  logic [1:0]         op,
   input  logic [5:0]         funct,
   input  logic [3:0]         rd,
   input  logic [3:0]         alu_flags,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               adr_src,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_write,
   output logic [1:0]         result_src,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_control,
   output logic [1:0]         imm_src,
   output logic [1:0]         reg_src,
   output logic [3:0]         flags,
   output logic [STATE_W-1:0] state
);

   state_t     r_state;
   state_t     w_next_state;
   logic [3:0] r_flags;

   logic       w_cond_ex;
   logic       w_set_flags;
   logic       w_rd_is_pc;
   logic [3:0] w_cmd;

   logic       w_pc_write;
   logic       w_adr_src;
   logic       w_mem_write;
   logic       w_ir_write;
   logic       w_reg_write;
   logic [1:0] w_result_src;
   logic       w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [1:0] w_alu_control;

   assign w_cmd       = funct[4:1];
   assign w_set_flags = funct[0];
   assign w_rd_is_pc  = (rd == 4'd15);

   arm_cond_check u_cond_check (
      .i_cond    (cond),
      .i_nzcv    (r_flags),
      .o_cond_ex (w_cond_ex)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // funct[0] is S only for data-processing, so flags are sampled only in the execute states.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_flags <= 4'b0000;
      end else if ((r_state == S_EXECR || r_state == S_EXECI) && w_set_flags) begin
         r_flags <= alu_flags;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_pc_write    = 1'b0;
      w_adr_src     = 1'b0;
      w_mem_write   = 1'b0;
      w_ir_write    = 1'b0;
      w_reg_write   = 1'b0;
      w_result_src  = RES_ALUOUT;
      w_alu_src_a   = 1'b0;
      w_alu_src_b   = SRCB_RD2;
      w_alu_control = ALU_ADD;

      case (r_state)
         S_FETCH: begin
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = SRCB_FOUR;
            w_result_src = RES_ALURESULT;
            w_ir_write   = mem_ready;
            w_pc_write   = mem_ready;
            w_next_state = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = SRCB_FOUR;
            w_result_src = RES_ALURESULT;
            if (!w_cond_ex) begin
               w_next_state = S_FETCH;
            end else begin
               case (op)
                  OP_DP:   w_next_state = funct[5] ? S_EXECI : S_EXECR;
                  OP_MEM:  w_next_state = S_MEMADR;
                  OP_BR:   w_next_state = S_BRANCH;
                  OP_UND:  w_next_state = S_FETCH;
                  default: w_next_state = S_FETCH;
               endcase
            end
         end
         S_MEMADR: begin
            w_alu_src_b  = SRCB_IMM;
            w_next_state = funct[0] ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            w_adr_src    = 1'b1;
            w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            w_result_src = RES_DATA;
            w_reg_write  = 1'b1;
            w_pc_write   = w_rd_is_pc;
            w_next_state = S_FETCH;
         end
         S_MEMWRITE: begin
            w_adr_src    = 1'b1;
            w_mem_write  = 1'b1;
            w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR, S_EXECI: begin
            w_alu_src_b   = (r_state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
            w_alu_control = cmd_to_alu(w_cmd);
            w_next_state  = (w_cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
         end
         S_ALUWB: begin
            w_reg_write  = 1'b1;
            w_pc_write   = w_rd_is_pc;
            w_next_state = S_FETCH;
         end
         S_BRANCH: begin
            w_alu_src_b  = SRCB_IMM;
            w_result_src = RES_ALURESULT;
            w_pc_write   = 1'b1;
            w_next_state = S_FETCH;
         end
         default: w_next_state = S_FETCH;
      endcase
   end

   // Write strobes are masked combinationally so nothing can fire while reset is low.
   assign pc_write    = w_pc_write & reset;
   assign ir_write    = w_ir_write & reset;
   assign reg_write   = w_reg_write & reset;
   assign mem_write   = w_mem_write & reset;
   assign adr_src     = w_adr_src;
   assign result_src  = w_result_src;
   assign alu_src_a   = w_alu_src_a;
   assign alu_src_b   = w_alu_src_b;
   assign alu_control = w_alu_control;
   assign imm_src     = op;
   assign reg_src     = {op == OP_MEM, op == OP_BR};
   assign flags       = r_flags;
   assign state       = STATE_W'(r_state);

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// tb/tb_arm_multicycle_ctrl.sv - scoreboard bench for arm_multicycle_ctrl
module tb_arm_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] alu_flags;
   logic       mem_ready;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
   logic [1:0] result_src, alu_src_b, alu_control, imm_src, reg_src;
   logic [3:0] flags;
   logic [3:0] state;

   always #5 clk = ~clk;

   arm_multicycle_ctrl #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd),
      .alu_flags(alu_flags), .mem_ready(mem_ready),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
      .reg_src(reg_src), .flags(flags), .state(state)
   );

   typedef struct {
      string      tag;
      logic [19:0] outs;
      logic [3:0]  flg;
   } exp_t;

   exp_t        sb[$];
   exp_t        m_e;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [3:0]  exp_flags = 4'b0000;
   logic [19:0] w_obs;

   assign w_obs = {state, pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                   alu_src_a, alu_src_b, alu_control, imm_src, reg_src};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // st pcw adr mw irw rw res sa sb ac imm rs
   function automatic logic [19:0] v(input int st, input int pcw, input int adr, input int mw,
                                     input int irw, input int rw, input int res, input int sa,
                                     input int sbv, input int ac, input int imm, input int rs);
      return {st[3:0], pcw[0], adr[0], mw[0], irw[0], rw[0], res[1:0], sa[0], sbv[1:0],
              ac[1:0], imm[1:0], rs[1:0]};
   endfunction

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         m_e = sb.pop_front();
         check({m_e.tag, "_outs"}, 32'(w_obs), 32'(m_e.outs));
         check({m_e.tag, "_flags"}, 32'(flags), 32'(m_e.flg));
      end
   end

   task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] r);
      cond = c; op = o; funct = f; rd = r;
   endtask

   task automatic cyc(input string tag, input logic mr, input logic [3:0] af, input logic [19:0] e);
      mem_ready = mr;
      alu_flags = af;
      sb.push_back('{tag, e, exp_flags});
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; mem_ready = 1'b0; alu_flags = 4'h0;
      set_instr(4'hE, 2'b00, 6'b000000, 4'd0);
      repeat (2) @(posedge clk);
      #1 mem_ready = 1'b1; alu_flags = 4'hF;
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      check("rst_pc_write", 32'(pc_write), 32'd0);
      check("rst_ir_write", 32'(ir_write), 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;

      // ADD R1,R2,R3 (no S, so the noisy alu_flags must be ignored)
      set_instr(4'hE, 2'b00, 6'b001000, 4'd1);
      cyc("add_fetch",  1'b1, 4'hF, v(0,1,0,0,1,0,2,1,2,0,0,0));
      cyc("add_decode", 1'b1, 4'hF, v(1,0,0,0,0,0,2,1,2,0,0,0));
      cyc("add_execr",  1'b1, 4'hF, v(6,0,0,0,0,0,0,0,0,0,0,0));
      cyc("add_aluwb",  1'b1, 4'hF, v(8,0,0,0,0,1,0,0,0,0,0,0));

      // SUBS R0,R1,R2 sets Z
      set_instr(4'hE, 2'b00, 6'b000101, 4'd0);
      cyc("subs_fetch",  1'b1, 4'h0, v(0,1,0,0,1,0,2,1,2,0,0,0));
      cyc("subs_decode", 1'b1, 4'h0, v(1,0,0,0,0,0,2,1,2,0,0,0));
      cyc("subs_execr",  1'b1, 4'b0100, v(6,0,0,0,0,0,0,0,0,1,0,0));
      exp_flags = 4'b0100;
      cyc("subs_aluwb",  1'b1, 4'h0, v(8,0,0,0,0,1,0,0,0,0,0,0));

      // BEQ taken, BNE not taken
      set_instr(4'h0, 2'b10, 6'b100000, 4'd0);
      cyc("beq_fetch",  1'b1, 4'b1011, v(0,1,0,0,1,0,2,1,2,0,2,1));
      cyc("beq_decode", 1'b1, 4'b1011, v(1,0,0,0,0,0,2,1,2,0,2,1));
      cyc("beq_branch", 1'b1, 4'b1011, v(9,1,0,0,0,0,2,0,1,0,2,1));
      set_instr(4'h1, 2'b10, 6'b100000, 4'd0);
      cyc("bne_fetch",  1'b1, 4'b1011, v(0,1,0,0,1,0,2,1,2,0,2,1));
      cyc("bne_decode", 1'b1, 4'b1011, v(1,0,0,0,0,0,2,1,2,0,2,1));

      // LDR R2 with a stalled fetch and three wait cycles in MEMREAD
      set_instr(4'hE, 2'b01, 6'b011001, 4'd2);
      cyc("ldr_fetch_wait", 1'b0, 4'h0, v(0,0,0,0,0,0,2,1,2,0,1,2));
      cyc("ldr_fetch",      1'b1, 4'h0, v(0,1,0,0,1,0,2,1,2,0,1,2));
      cyc("ldr_decode",     1'b1, 4'h0, v(1,0,0,0,0,0,2,1,2,0,1,2));
      cyc("ldr_memadr",     1'b1, 4'h0, v(2,0,0,0,0,0,0,0,1,0,1,2));
      for (int i = 0; i < 3; i++)
         cyc("ldr_memread_wait", 1'b0, 4'h0, v(3,0,1,0,0,0,0,0,0,0,1,2));
      cyc("ldr_memread",    1'b1, 4'h0, v(3,0,1,0,0,0,0,0,0,0,1,2));
      cyc("ldr_memwb",      1'b1, 4'h0, v(4,0,0,0,0,1,1,0,0,0,1,2));

      // LDR PC also loads the PC in MEMWB
      set_instr(4'hE, 2'b01, 6'b011001, 4'd15);
      cyc("ldrpc_fetch",   1'b1, 4'h0, v(0,1,0,0,1,0,2,1,2,0,1,2));
      cyc("ldrpc_decode",  1'b1, 4'h0, v(1,0,0,0,0,0,2,1,2,0,1,2));
      cyc("ldrpc_memadr",  1'b1, 4'h0, v(2,0,0,0,0,0,0,0,1,0,1,2));
      cyc("ldrpc_memread", 1'b1, 4'h0, v(3,0,1,0,0,0,0,0,0,0,1,2));
      cyc("ldrpc_memwb",   1'b1, 4'h0, v(4,1,0,0,0,1,1,0,0,0,1,2));

      // STR with two wait cycles
      set_instr(4'hE, 2'b01, 6'b011000, 4'd3);
      cyc("str_fetch",  1'b1, 4'h0, v(0,1,0,0,1,0,2,1,2,0,1,2));
      cyc("str_decode", 1'b1, 4'h0, v(1,0,0,0,0,0,2,1,2,0,1,2));
      cyc("str_memadr", 1'b1, 4'h0, v(2,0,0,0,0,0,0,0,1,0,1,2));
      cyc("str_memwrite_wait", 1'b0, 4'h0, v(5,0,1,1,0,0,0,0,0,0,1,2));
      cyc("str_memwrite_wait", 1'b0, 4'h0, v(5,0,1,1,0,0,0,0,0,0,1,2));
      cyc("str_memwrite",      1'b1, 4'h0, v(5,0,1,1,0,0,0,0,0,0,1,2));

      // CMP R1,#5: three cycles, flags only
      set_instr(4'hE, 2'b00, 6'b110101, 4'd0);
      cyc("cmp_fetch",  1'b1, 4'h0, v(0,1,0,0,1,0,2,1,2,0,0,0));
      cyc("cmp_decode", 1'b1, 4'h0, v(1,0,0,0,0,0,2,1,2,0,0,0));
      cyc("cmp_execi",  1'b1, 4'b1000, v(7,0,0,0,0,0,0,0,1,1,0,0));
      exp_flags = 4'b1000;

      // ORR PC,#imm (no S) writes PC in ALUWB
      set_instr(4'hE, 2'b00, 6'b111000, 4'd15);
      cyc("orr_fetch",  1'b1, 4'b0110, v(0,1,0,0,1,0,2,1,2,0,0,0));
      cyc("orr_decode", 1'b1, 4'b0110, v(1,0,0,0,0,0,2,1,2,0,0,0));
      cyc("orr_execi",  1'b1, 4'b0110, v(7,0,0,0,0,0,0,0,1,3,0,0));
      cyc("orr_aluwb",  1'b1, 4'b0110, v(8,1,0,0,0,1,0,0,0,0,0,0));

      // AND reg and an unlisted command (defaults to ADD)
      set_instr(4'hE, 2'b00, 6'b000000, 4'd4);
      cyc("and_fetch",  1'b1, 4'h0, v(0,1,0,0,1,0,2,1,2,0,0,0));
      cyc("and_decode", 1'b1, 4'h0, v(1,0,0,0,0,0,2,1,2,0,0,0));
      cyc("and_execr",  1'b1, 4'h0, v(6,0,0,0,0,0,0,0,0,2,0,0));
      cyc("and_aluwb",  1'b1, 4'h0, v(8,0,0,0,0,1,0,0,0,0,0,0));
      set_instr(4'hE, 2'b00, 6'b011010, 4'd5);
      cyc("mov_fetch",  1'b1, 4'h0, v(0,1,0,0,1,0,2,1,2,0,0,0));
      cyc("mov_decode", 1'b1, 4'h0, v(1,0,0,0,0,0,2,1,2,0,0,0));
      cyc("mov_execr",  1'b1, 4'h0, v(6,0,0,0,0,0,0,0,0,0,0,0));
      cyc("mov_aluwb",  1'b1, 4'h0, v(8,0,0,0,0,1,0,0,0,0,0,0));

      // Condition failures: PL with N=1, and the never code
      set_instr(4'h5, 2'b00, 6'b001001, 4'd15);
      cyc("pl_fetch",  1'b1, 4'b0001, v(0,1,0,0,1,0,2,1,2,0,0,0));
      cyc("pl_decode", 1'b1, 4'b0001, v(1,0,0,0,0,0,2,1,2,0,0,0));
      set_instr(4'hF, 2'b10, 6'b100000, 4'd0);
      cyc("nv_fetch",  1'b1, 4'h0, v(0,1,0,0,1,0,2,1,2,0,2,1));
      cyc("nv_decode", 1'b1, 4'h0, v(1,0,0,0,0,0,2,1,2,0,2,1));

      // Undefined op=11
      set_instr(4'hE, 2'b11, 6'b000000, 4'd0);
      cyc("und_fetch",  1'b1, 4'h0, v(0,1,0,0,1,0,2,1,2,0,3,0));
      cyc("und_decode", 1'b1, 4'h0, v(1,0,0,0,0,0,2,1,2,0,3,0));

      // Reset asserted mid-MEMWRITE
      set_instr(4'hE, 2'b01, 6'b011000, 4'd6);
      cyc("rstr_fetch",  1'b1, 4'h0, v(0,1,0,0,1,0,2,1,2,0,1,2));
      cyc("rstr_decode", 1'b1, 4'h0, v(1,0,0,0,0,0,2,1,2,0,1,2));
      cyc("rstr_memadr", 1'b1, 4'h0, v(2,0,0,0,0,0,0,0,1,0,1,2));
      mem_ready = 1'b0;
      sb.push_back('{"rstr_memwrite", v(5,0,1,1,0,0,0,0,0,0,1,2), exp_flags});
      @(negedge clk);
      #1 reset = 1'b0; mem_ready = 1'b1;
      #1;
      check("async_rst_state", 32'(state), 32'd0);
      check("async_rst_flags", 32'(flags), 32'd0);
      check("async_rst_mem_write", 32'(mem_write), 32'd0);
      check("async_rst_pc_write", 32'(pc_write), 32'd0);
      check("async_rst_ir_write", 32'(ir_write), 32'd0);
      exp_flags = 4'b0000;
      @(posedge clk);
      #1;
      check("held_rst_state", 32'(state), 32'd0);
      reset = 1'b1;

      set_instr(4'hE, 2'b00, 6'b001000, 4'd1);
      cyc("add2_fetch",  1'b1, 4'h0, v(0,1,0,0,1,0,2,1,2,0,0,0));
      cyc("add2_decode", 1'b1, 4'h0, v(1,0,0,0,0,0,2,1,2,0,0,0));
      cyc("add2_execr",  1'b1, 4'h0, v(6,0,0,0,0,0,0,0,0,0,0,0));
      cyc("add2_aluwb",  1'b1, 4'h0, v(8,0,0,0,0,1,0,0,0,0,0,0));

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
